// File: rtl/cpu_program_loader.sv
// cpu_program_loader: collects a program from a valid/ready word stream into
// an internal buffer, then replays it gaplessly into the CPU instruction-load
// port while framing the load with CpuReset pulses.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR checksum of accepted words);
// when undefined, Checksum is tied to zero.
module cpu_program_loader #(
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       InData,
  input  logic              InLast,
  input  logic              Reload,
  output logic              CpuReset,
  output logic              LoadInstructions,
  output logic [31:0]       Instruction,
  output logic              Running,
  output logic [ADDR_W:0]   WordCount,
  output logic              Overflow,
  output logic [31:0]       Checksum
);
  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] FULL_M1 = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {COLLECT, PRE_RST, LOAD, POST_RST, RUN} loaderState_t;

  loaderState_t state;
  logic [31:0] progBuf [DEPTH];
  logic [CNT_W-1:0] phaseCnt;
  logic [ADDR_W:0] loadIdx;
  logic xfer;

  // Ready is combinational so it drops the instant Reset goes low.
  assign InReady = (state == COLLECT) && (WordCount < FULL) && Reset;
  assign xfer = InValid && InReady;

  // Program buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (xfer) progBuf[WordCount[ADDR_W-1:0]] <= InData;
  end

  // Sequencer: collection, CPU reset framing and gapless replay.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state            <= COLLECT;
      WordCount        <= '0;
      CpuReset         <= 1'b1;
      LoadInstructions <= 1'b0;
      Instruction      <= '0;
      Running          <= 1'b0;
      Overflow         <= 1'b0;
      phaseCnt         <= '0;
      loadIdx          <= '0;
    end else begin
      case (state)
        COLLECT: begin
          CpuReset <= 1'b1;
          if (xfer) begin
            WordCount <= WordCount + 1'b1;
            if (InLast || (WordCount == FULL_M1)) begin
              state    <= PRE_RST;
              phaseCnt <= '0;
            end
            // Filling the last slot without an end marker truncates the program.
            if (!InLast && (WordCount == FULL_M1)) Overflow <= 1'b1;
          end
        end
        PRE_RST: begin
          CpuReset <= 1'b1;
          if (phaseCnt == CNT_LAST) begin
            state   <= LOAD;
            loadIdx <= '0;
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        LOAD: begin
          CpuReset <= 1'b0;
          if (loadIdx == WordCount) begin
            // One idle cycle after the last word before the flush reset.
            LoadInstructions <= 1'b0;
            Instruction      <= '0;
            state            <= POST_RST;
            phaseCnt         <= '0;
          end else begin
            LoadInstructions <= 1'b1;
            Instruction      <= progBuf[loadIdx[ADDR_W-1:0]];
            loadIdx          <= loadIdx + 1'b1;
          end
        end
        POST_RST: begin
          CpuReset <= 1'b1;
          if (phaseCnt == CNT_LAST) begin
            state <= RUN;
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        RUN: begin
          if (Reload) begin
            state     <= COLLECT;
            WordCount <= '0;
            Overflow  <= 1'b0;
            CpuReset  <= 1'b1;
            Running   <= 1'b0;
          end else begin
            CpuReset <= 1'b0;
            Running  <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksumReg;

  // XOR accumulator over accepted words; naturally frozen outside COLLECT.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      checksumReg <= '0;
    end else if ((state == RUN) && Reload) begin
      checksumReg <= '0;
    end else if (xfer) begin
      checksumReg <= checksumReg ^ InData;
    end
  end

  assign Checksum = checksumReg;
`else
  assign Checksum = '0;
`endif

endmodule

// File: tb/tb_cpu_program_loader.sv
// Self-checking bench for cpu_program_loader: directed program scenarios plus
// randomized programs, checked cycle by cycle against a phase-level model.
module tb_cpu_program_loader;
  localparam int DEPTH = 32;
  localparam int ADDR_W = 5;
  localparam int RST_CYCLES = 2;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic InValid = 1'b0;
  logic InLast = 1'b0;
  logic Reload = 1'b0;
  logic [31:0] InData = '0;
  logic InReady, CpuReset, LoadInstructions, Running, Overflow;
  logic [31:0] Instruction, Checksum;
  logic [ADDR_W:0] WordCount;

  int total = 0;
  int bad = 0;

  cpu_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InData(InData), .InLast(InLast), .Reload(Reload), .CpuReset(CpuReset),
    .LoadInstructions(LoadInstructions), .Instruction(Instruction),
    .Running(Running), .WordCount(WordCount), .Overflow(Overflow),
    .Checksum(Checksum)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expChecksum(input logic [31:0] prog[$]);
    logic [31:0] acc = '0;
`ifdef LOADER_CHECKSUM_EN
    foreach (prog[i]) acc ^= prog[i];
`endif
    return acc;
  endfunction

  // Expected {CpuReset, LoadInstructions, Running, Instruction} k cycles after
  // the final transfer, from the phase lengths of the load sequence.
  function automatic logic [63:0] expAt(input int k, input logic [31:0] prog[$]);
    int n = prog.size();
    logic cr = 1'b0, li = 1'b0, run = 1'b0;
    logic [31:0] ins = '0;
    if (k <= RST_CYCLES) cr = 1'b1;
    else if (k <= RST_CYCLES + n) begin li = 1'b1; ins = prog[k - RST_CYCLES - 1]; end
    else if (k == RST_CYCLES + n + 1) begin end
    else if (k <= 2 * RST_CYCLES + n + 1) cr = 1'b1;
    else run = 1'b1;
    return {28'd0, cr, li, run, 1'b0, ins};
  endfunction

  function automatic logic [63:0] obsTuple();
    return {28'd0, CpuReset, LoadInstructions, Running, 1'b0, Instruction};
  endfunction

  task automatic sendWord(input logic [31:0] w, input logic last, input int gap);
    int waited = 0;
    InValid = 1'b0;
    repeat (gap) step();
    InValid = 1'b1;
    InData = w;
    InLast = last;
    while (!InReady && waited < 100) begin
      step();
      waited++;
    end
    if (!InReady) chk("ready_timeout", {63'd0, InReady}, 64'd1);
    step();
    InValid = 1'b0;
    InLast = 1'b0;
    InData = '0;
  endtask

  // gap < 0 selects a random gap of 0..3 cycles before each word after the first.
  task automatic sendProgram(input logic [31:0] prog[$], input bit withLast, input int gap);
    for (int i = 0; i < prog.size(); i++) begin
      int g = (i == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 3)) : gap);
      sendWord(prog[i], withLast && (i == prog.size() - 1), g);
    end
  endtask

  task automatic checkLoad(input string name, input logic [31:0] prog[$], input bit withLast);
    int n = prog.size();
    logic expOvf = !withLast && (n == DEPTH);
    chk({name, "_ready_after_last"}, {63'd0, InReady}, 64'd0);
    chk({name, "_ovf_early"}, {63'd0, Overflow}, {63'd0, expOvf});
    for (int k = 1; k <= 2 * RST_CYCLES + n + 2; k++) begin
      step();
      chk($sformatf("%s_trace_k%0d", name, k), obsTuple(), expAt(k, prog));
    end
    chk({name, "_wordcount"}, {58'd0, WordCount}, 64'(n));
    chk({name, "_overflow"}, {63'd0, Overflow}, {63'd0, expOvf});
    chk({name, "_ready_run"}, {63'd0, InReady}, 64'd0);
    chk({name, "_checksum"}, {32'd0, Checksum}, {32'd0, expChecksum(prog)});
    $display("program %s len=%0d last=%0d checked", name, n, withLast);
  endtask

  task automatic doReload();
    Reload = 1'b1;
    step();
    Reload = 1'b0;
    chk("reload_cpureset", {63'd0, CpuReset}, 64'd1);
    chk("reload_running", {63'd0, Running}, 64'd0);
    chk("reload_wordcount", {58'd0, WordCount}, 64'd0);
    chk("reload_overflow", {63'd0, Overflow}, 64'd0);
    chk("reload_checksum", {32'd0, Checksum}, 64'd0);
    chk("reload_ready", {63'd0, InReady}, 64'd1);
  endtask

  task automatic checkResetValues(input string name);
    chk({name, "_cpureset"}, {63'd0, CpuReset}, 64'd1);
    chk({name, "_loadinstr"}, {63'd0, LoadInstructions}, 64'd0);
    chk({name, "_instr"}, {32'd0, Instruction}, 64'd0);
    chk({name, "_running"}, {63'd0, Running}, 64'd0);
    chk({name, "_wordcount"}, {58'd0, WordCount}, 64'd0);
    chk({name, "_overflow"}, {63'd0, Overflow}, 64'd0);
    chk({name, "_checksum"}, {32'd0, Checksum}, 64'd0);
    chk({name, "_ready"}, {63'd0, InReady}, 64'd0);
  endtask

  initial begin
    logic [31:0] prog[$];

    // Power-on reset
    #1 Reset = 1'b0;
    step();
    step();
    checkResetValues("por");
    Reset = 1'b1;
    step();
    chk("por_ready_released", {63'd0, InReady}, 64'd1);

    // Three-word program, back to back
    prog = '{32'h20010005, 32'h20020003, 32'h00221820};
    sendProgram(prog, 1'b1, 0);
    checkLoad("basic3", prog, 1'b1);

    // Same program with 4-cycle valid gaps
    doReload();
    sendProgram(prog, 1'b1, 4);
    checkLoad("gapped3", prog, 1'b1);

    // Full buffer without an end marker
    doReload();
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    sendProgram(prog, 1'b0, -1);
    checkLoad("overflow32", prog, 1'b0);

    // Full buffer with the end marker on the last slot
    doReload();
    prog = {};
    for (int i = 0; i < DEPTH; i++) prog.push_back($urandom);
    sendProgram(prog, 1'b1, 0);
    checkLoad("full32_last", prog, 1'b1);

    // Randomized programs
    for (int r = 0; r < 5; r++) begin
      int len = int'($urandom_range(1, DEPTH));
      doReload();
      prog = {};
      for (int i = 0; i < len; i++) prog.push_back($urandom);
      sendProgram(prog, 1'b1, -1);
      checkLoad($sformatf("rand%0d", r), prog, 1'b1);
    end

    // Reset during the second load cycle
    doReload();
    prog = '{$urandom, $urandom, $urandom};
    sendProgram(prog, 1'b1, 0);
    repeat (RST_CYCLES + 2) step();
    chk("abort_in_load", obsTuple(), expAt(RST_CYCLES + 2, prog));
    Reset = 1'b0;
    #1;
    checkResetValues("abort");
    step();
    step();
    Reset = 1'b1;
    step();
    prog = '{$urandom};
    sendProgram(prog, 1'b1, 0);
    checkLoad("after_abort", prog, 1'b1);

    // Reload then a single all-ones word
    doReload();
    prog = '{32'hFFFFFFFF};
    sendProgram(prog, 1'b1, 0);
    checkLoad("ones1", prog, 1'b1);

    // Checksum pattern
    doReload();
    prog = '{32'h0000000F, 32'h000000F0};
    sendProgram(prog, 1'b1, 0);
    checkLoad("csum2", prog, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
